multicycle_sequencer: RTL
=========================

MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset: clk and rst.
REQ-002 The block SHALL have parameter NUM_REGS, default 4, giving the register-file entries and the reg_en width; legal values are 2..16.
REQ-003 The block SHALL have parameter RD_W, default $clog2(NUM_REGS), giving the rd width.
REQ-004 The block SHALL have parameter TIMEOUT_CYC, default 255, giving the maximum handshake wait in cycles; it is 8 bits.
REQ-005 The block SHALL have the following ports:
- clk in 1 clock.
- rst in 1 synchronous active-low reset.
- en_in in 1 start request.
- en1 in 1 fetch-complete.
- en2 in 1 execute-complete.
- zero in 1 ALU zero flag.
- rd in RD_W destination register.
- opcode in 4 instruction opcode.
- en_fetch_pulse out 1 fetch strobe.
- en_group_pulse out 1 operand/ALU strobe.
- en_pc_pulse out 1 PC update strobe.
- pc_ctrl out 2 PC op: 00 hold, 01 increment, 10 load.
- reg_en out NUM_REGS one-hot write enable.
- alu_in_sel out 1 ALU operand select.
- alu_func out 3 ALU op.
- illegal_op out 1 undefined-opcode strobe.
- halted out 1 HALT status.
- timeout out 1 watchdog strobe.

Function
REQ-006 States SHALL be IDLE, FETCH, DECODE, EXEC, JUMP, WB, HALT.
REQ-007 All outputs SHALL be registered and SHALL be functions of the current state only, with no combinational input-to-output path.
REQ-008 Transitions SHALL be:
- IDLE->FETCH when en_in=1.
- FETCH->DECODE when en1=1.
- DECODE->EXEC for MOVEB 0000, ADD 0010, SUB 0101, AND 0111, OR 1001.
- DECODE->JUMP for JMP 1010, and for BRZ 1011 when zero=1.
- DECODE->FETCH for BRZ with zero=0.
- DECODE->HALT for HALT 1111.
- EXEC->WB when en2=1.
- JUMP->FETCH and WB->FETCH unconditionally.
REQ-009 Any other opcode in DECODE SHALL raise illegal_op for one cycle and return to FETCH.
REQ-010 Inputs SHALL be ignored outside the states that sample them: en1 only in FETCH, en2 only in EXEC, en_in only in IDLE.
REQ-011 Strobe timing SHALL be:
- en_fetch_pulse: exactly the first cycle of each FETCH visit.
- en_pc_pulse: the first cycle of FETCH (pc_ctrl=01) and of JUMP (pc_ctrl=10).
- en_group_pulse: the first cycle of EXEC.
- On consecutive visits to the same state, each visit SHALL produce a fresh one-cycle strobe.
REQ-012 alu_func/alu_in_sel SHALL be MOVEB 000/0, ADD 001/0, SUB 010/1, AND 011/1, OR 100/1, and SHALL be held through EXEC and WB; they SHALL be 000/0 elsewhere.
REQ-013 reg_en SHALL be one-hot at bit rd for exactly the one WB cycle and zero otherwise; rd SHALL be captured in DECODE.
REQ-014 halted SHALL be 1 throughout HALT; HALT SHALL be exited only by reset.
REQ-015 pc_ctrl SHALL be 00 except in FETCH and JUMP.
REQ-016 Minimum cycle counts SHALL be: ALU instruction 4 cycles (FETCH, DECODE, EXEC, WB) with en1 and en2 high on first sampling; jump 3 cycles.

Reset
REQ-017 With rst=0 at a clk edge, the state SHALL become IDLE and every output SHALL be 0, including mid-instruction; rst SHALL take priority over all inputs.
REQ-018 The first cycle after reset release SHALL be IDLE regardless of en_in.

Configuration
REQ-019 With CTRL_TIMEOUT_EN defined:
- A counter SHALL count consecutive cycles waiting in FETCH (en1=0) or EXEC (en2=0).
- On reaching TIMEOUT_CYC, timeout SHALL pulse for one cycle and the FSM SHALL return to IDLE.
- The counter SHALL clear on every state change.
REQ-020 Without CTRL_TIMEOUT_EN, timeout SHALL be tied to 0, no counter SHALL exist, and waits SHALL be unbounded.

Structure
REQ-021 Package ctrl_pkg SHALL hold the state enum, the opcode constants, the alu_func encodings and the pc_ctrl encodings.
REQ-022 Sub-module ctrl_opdec SHALL decode the opcode combinationally into class (alu/jmp/brz/halt/illegal), alu_func and alu_in_sel.

Verification
REQ-023 The bench SHALL cover at least these scenarios:
- Reset, then en_in=1, en1=1, ADD 0010, rd=2, en2=1 -> reg_en=0100 for one cycle on the 4th cycle after FETCH entry; alu_func=001.
- BRZ 1011 with zero=0 -> FETCH follows DECODE with no pc_ctrl=10; with zero=1 -> JUMP with en_pc_pulse and pc_ctrl=10 for one cycle.
- Opcode 0011 -> illegal_op for one cycle, then FETCH with a fresh en_fetch_pulse.
- HALT 1111 -> halted=1 held for 100 cycles despite en_in toggling; rst=0 clears it.
- CTRL_TIMEOUT_EN, TIMEOUT_CYC=10, en2 held 0 in EXEC -> timeout after 10 wait cycles, then IDLE; without the macro, EXEC is held for 1000 cycles.
- rst=0 asserted during WB -> next cycle reg_en=0 and state IDLE.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle sequencer: FSM states,
// opcode classes, opcode values, ALU function codes and PC control codes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    JUMP,
    WB,
    HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_JMP,
    CLS_BRZ,
    CLS_HALT,
    CLS_ILLEGAL
  } op_class_t;

  localparam logic [3:0] OP_MOVEB = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0101;
  localparam logic [3:0] OP_AND   = 4'b0111;
  localparam logic [3:0] OP_OR    = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1010;
  localparam logic [3:0] OP_BRZ   = 4'b1011;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [2:0] ALU_MOVEB = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;

  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_LOAD = 2'b10;

endpackage

// File: rtl/ctrl_opdec.sv
// Combinational opcode decoder: instruction class plus the ALU function
// and operand select that an ALU-class opcode will use in EXEC/WB.
module ctrl_opdec
  import ctrl_pkg::*;
(
  input  logic [3:0] opcode,
  output op_class_t  op_class,
  output logic [2:0] alu_func,
  output logic       alu_in_sel
);

  always_comb begin
    op_class   = CLS_ILLEGAL;
    alu_func   = ALU_MOVEB;
    alu_in_sel = 1'b0;
    case (opcode)
      OP_MOVEB: op_class = CLS_ALU;
      OP_ADD: begin
        op_class = CLS_ALU;
        alu_func = ALU_ADD;
      end
      OP_SUB: begin
        op_class   = CLS_ALU;
        alu_func   = ALU_SUB;
        alu_in_sel = 1'b1;
      end
      OP_AND: begin
        op_class   = CLS_ALU;
        alu_func   = ALU_AND;
        alu_in_sel = 1'b1;
      end
      OP_OR: begin
        op_class   = CLS_ALU;
        alu_func   = ALU_OR;
        alu_in_sel = 1'b1;
      end
      OP_JMP:  op_class = CLS_JMP;
      OP_BRZ:  op_class = CLS_BRZ;
      OP_HALT: op_class = CLS_HALT;
      default: op_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle instruction sequencer FSM with fully registered strobes.
// Optional handshake watchdog enabled by defining CTRL_TIMEOUT_EN.
module multicycle_sequencer
  import ctrl_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 4,
  parameter int unsigned RD_W        = $clog2(NUM_REGS),
  parameter logic [7:0]  TIMEOUT_CYC = 8'd255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_in,
  input  logic                en1,
  input  logic                en2,
  input  logic                zero,
  input  logic [RD_W-1:0]     rd,
  input  logic [3:0]          opcode,
  output logic                en_fetch_pulse,
  output logic                en_group_pulse,
  output logic                en_pc_pulse,
  output logic [1:0]          pc_ctrl,
  output logic [NUM_REGS-1:0] reg_en,
  output logic                alu_in_sel,
  output logic [2:0]          alu_func,
  output logic                illegal_op,
  output logic                halted,
  output logic                timeout
);

  if (NUM_REGS < 2 || NUM_REGS > 16 || TIMEOUT_CYC == 8'd0) begin : g_bad_param
    $error("multicycle_sequencer: NUM_REGS must be 2..16 and TIMEOUT_CYC nonzero");
  end

  state_t          state;
  state_t          next_state;
  op_class_t       op_class;
  logic [2:0]      dec_func;
  logic            dec_sel;
  logic [RD_W-1:0] rd_q;
  logic            expired;

  ctrl_opdec u_opdec (
    .opcode     (opcode),
    .op_class   (op_class),
    .alu_func   (dec_func),
    .alu_in_sel (dec_sel)
  );

`ifdef CTRL_TIMEOUT_EN
  logic [7:0] wait_cnt;

  assign expired = ((state == FETCH && !en1) || (state == EXEC && !en2))
                   && (wait_cnt == TIMEOUT_CYC - 8'd1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= expired;
      if (next_state != state)
        wait_cnt <= '0;
      else if (state == FETCH || state == EXEC)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end
`else
  assign expired = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (en_in) next_state = FETCH;
      FETCH: begin
        if (en1)          next_state = DECODE;
        else if (expired) next_state = IDLE;
      end
      DECODE: begin
        case (op_class)
          CLS_ALU:  next_state = EXEC;
          CLS_JMP:  next_state = JUMP;
          CLS_BRZ:  next_state = zero ? JUMP : FETCH;
          CLS_HALT: next_state = HALT;
          default:  next_state = FETCH;
        endcase
      end
      EXEC: begin
        if (en2)          next_state = WB;
        else if (expired) next_state = IDLE;
      end
      JUMP:    next_state = FETCH;
      WB:      next_state = FETCH;
      HALT:    next_state = HALT;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are computed from the state being entered and registered, so
  // during each cycle they reflect the current state with no input path.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      rd_q           <= '0;
      en_fetch_pulse <= 1'b0;
      en_group_pulse <= 1'b0;
      en_pc_pulse    <= 1'b0;
      pc_ctrl        <= PC_HOLD;
      reg_en         <= '0;
      alu_in_sel     <= 1'b0;
      alu_func       <= ALU_MOVEB;
      illegal_op     <= 1'b0;
      halted         <= 1'b0;
    end else begin
      state <= next_state;
      if (state == DECODE) rd_q <= rd;

      en_fetch_pulse <= (next_state == FETCH) && (state != FETCH);
      en_group_pulse <= (next_state == EXEC) && (state != EXEC);
      en_pc_pulse    <= (next_state != state) && (next_state == FETCH || next_state == JUMP);

      case (next_state)
        FETCH:   pc_ctrl <= PC_INC;
        JUMP:    pc_ctrl <= PC_LOAD;
        default: pc_ctrl <= PC_HOLD;
      endcase

      reg_en <= (next_state == WB) ? (NUM_REGS'(1) << rd_q) : '0;

      if (next_state == EXEC || next_state == WB) begin
        if (state == DECODE) begin
          alu_func   <= dec_func;
          alu_in_sel <= dec_sel;
        end
      end else begin
        alu_func   <= ALU_MOVEB;
        alu_in_sel <= 1'b0;
      end

      illegal_op <= (state == DECODE) && (op_class == CLS_ILLEGAL);
      halted     <= (next_state == HALT);
    end
  end

endmodule
